sum_stream_buffer: RTL
======================

Name: sum_stream_buffer

Overview:
- Stage directly downstream of the pipelined adding machine.
- Captures the machine's 32-bit running-sum output into a small FIFO.
- Presents captured sums to a consumer over a valid/ready handshake.
- Counts sums lost to back-pressure.

Parameters:
- ADDR_W, 2, FIFO pointer width.
- DEPTH, 4, FIFO entries; must equal 2**ADDR_W (elaboration-time check).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  reset; asynchronous, active-low (0 = in reset).
- in_data  input  32  running sum from the adding machine.
- in_valid  input  1  in_data is a sum to capture this cycle.
- out_data  output  32  head-of-FIFO sum.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- count  output  ADDR_W+1  entries held, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- drop_count  output  16  saturating count of sums lost while full.

Behaviour:
- Reset (reset low, async assert, sync-to-clk deassert by upstream): rd/wr pointers 0, count 0, drop_count 0, all entries 0.
- Reset output values: out_data 0, out_valid 0, empty 1, full 0.
- Reset asserted mid-operation discards all held entries immediately.
- push = in_valid && (!full || pop). pop = out_valid && out_ready.
- Push: entry[wr_ptr] <= stored value; wr_ptr += 1 mod DEPTH.
- Pop: rd_ptr += 1 mod DEPTH.
- Pointer wrap from DEPTH-1 to 0 is seamless.
- count update on each edge: +1 on push only, -1 on pop only, unchanged on both or neither.
- out_data = entry[rd_ptr], combinational from state. out_valid = !empty.
- out_data is undefined-but-stable when empty; it holds the last written or reset value there.
- Latency: sum pushed at edge N is visible at out_data/out_valid after edge N. There is no combinational in->out bypass.
- Empty + in_valid + out_ready: push only; no pop, since out_valid is 0.
- Full + in_valid + out_ready: pop and push both occur; count stays DEPTH; no drop.
- Full + in_valid + !out_ready: sum discarded; drop_count += 1, saturating at 16'hFFFF.
- Entries and pointers are unchanged when neither push nor pop occurs.
- No other state machine. FIFO occupancy is the only state: EMPTY -> PARTIAL -> FULL and back, by count.

Optional Feature:
- Macro: SUM_DELTA_EN.
- Defined:
  - Adds internal 32-bit prev register, reset 0.
  - Stored value = in_data - prev, mod 2^32; recovers the per-cycle addend.
  - prev <= in_data only on accepted pushes; dropped sums do not update prev.
  - The delta after a drop therefore spans the lost interval.
- Undefined:
  - Stored value = in_data unchanged.
  - No prev register is synthesized.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release -> out_valid=0, empty=1, count=0, out_data=0, drop_count=0.
- Single pass: push 32'h5 with out_ready=0, then push 32'h11 -> count=2; raise out_ready -> out_data 5 then 0x11, empty=1 after 2 pops.
- Fill and drop: push 1,2,3,4,5,6 with out_ready=0 -> full=1 after 4th, drop_count=2; drain yields 1,2,3,4 in order.
- Full with simultaneous push/pop: from full {1,2,3,4}, in_data=9 and out_ready=1 for one cycle -> count stays 4, drop_count unchanged, drain yields 2,3,4,9.
- Wrap and async reset: 10 push/pop cycles across the pointer wrap, data in order; assert reset mid-stream between edges -> count=0, out_valid=0 immediately.
- SUM_DELTA_EN: push sums 3, 10, 10, 32'h0000_0002 (wrapped) -> outputs 3, 7, 0, 32'hFFFF_FFF8.

Source files
------------

// File: rtl/sum_stream_buffer.sv
// sum_stream_buffer
// Captures the adding machine's 32-bit running sum into a small FIFO and
// hands the captured sums to a consumer over a valid/ready handshake.
// Sums that arrive while the FIFO is full and not draining are lost and
// counted in a saturating drop counter.
//
// Optional feature macro: SUM_DELTA_EN
//   defined   : each stored value is in_data minus the previously accepted
//               sum (mod 2^32), recovering the per-cycle addend.
//   undefined : in_data is stored unchanged and no prev register exists.

module sum_stream_buffer #(
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic [15:0]       drop_count
);

    // The pointers wrap by natural overflow, which only works for a power of two.
    generate
        if (DEPTH != (2 ** ADDR_W)) begin : g_depth_check
            $error("sum_stream_buffer: DEPTH must equal 2**ADDR_W");
        end
    endgenerate

    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [31:0]       stored;
    logic              push;
    logic              pop;
    logic              drop;

    assign empty     = (count == '0);
    assign full      = (count == DEPTH_C);
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr];

    // A full FIFO can still accept a sum when the consumer frees a slot in the same cycle.
    always_comb begin
        pop  = out_valid && out_ready;
        push = in_valid && (!full || pop);
        drop = in_valid && full && !pop;
    end

`ifdef SUM_DELTA_EN
    logic [31:0] prev;

    // Remember the last accepted running sum; dropped sums leave it alone so the next delta spans the gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev <= '0;
        end else if (push) begin
            prev <= in_data;
        end
    end

    // Store the difference from the previous accepted sum, wrapping mod 2^32.
    always_comb begin
        stored = in_data - prev;
    end
`else
    // Store the running sum as-is.
    always_comb begin
        stored = in_data;
    end
`endif

    // Entry storage and write pointer; reset clears every entry so out_data reads 0 afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (push) begin
            mem[wr_ptr] <= stored;
            wr_ptr      <= wr_ptr + ADDR_W'(1);
        end
    end

    // Read pointer advances on each accepted handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
        end
    end

    // Occupancy tracks push/pop; simultaneous push and pop cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Count sums lost to back-pressure, sticking at the maximum rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

endmodule
